// File: rtl/level_ctrl_pkg.sv
// Shared definitions for the game-level sequencer: FSM state encodings,
// the default level width and a small constant helper.
package level_ctrl_pkg;

    // Default width of the level bus, shared with the HUD and enemy modules.
    localparam int LEVEL_W_DEF = 4;

    // Sequencer states, 2-bit encoding visible to other subsystems.
    typedef enum logic [1:0] {
        ST_PLAY       = 2'd0,
        ST_CLEAR_WAIT = 2'd1,
        ST_RESPAWN    = 2'd2,
        ST_WON        = 2'd3
    } level_state_e;

    // Larger of two integers; used to size the shared dwell counter.
    function automatic int max_int(input int a, input int b);
        int r;
        if (a > b) begin
            r = a;
        end else begin
            r = b;
        end
        return r;
    endfunction

endpackage

// File: rtl/level_ctrl_enemy_popcount.sv
// Combinational population count of the enemy alive flags.
// The result is registered by the parent so no comb path reaches an output.
module enemy_popcount
    import level_ctrl_pkg::*;
#(
    parameter int N = 5,
    parameter int W = $clog2(N + 1)
) (
    input  logic [N-1:0] alive,
    output logic [W-1:0] count
);

    // Sum the individual alive bits.
    always_comb begin
        count = {W{1'b0}};
        for (int i = 0; i < N; i++) begin
            count = count + W'(alive[i]);
        end
    end

endmodule

// File: rtl/level_ctrl.sv
// Game-level sequencer: detects a cleared wave once armed, advances the
// level (with wrap or win at the cap), holds a pausable banner delay and
// then pulses the respawn strobe for a fixed number of cycles.
module level_ctrl
    import level_ctrl_pkg::*;
#(
    parameter int NUM_ENEMIES    = 5,
    parameter int LEVEL_W        = LEVEL_W_DEF,
    parameter int MAX_LEVEL      = 9,
    parameter int DELAY_CYCLES   = 100_000_000,
    parameter int RESPAWN_CYCLES = 100,
    parameter bit WRAP_EN        = 1'b0
) (
    input  logic                               pclk,
    input  logic                               rst,
    input  logic [NUM_ENEMIES-1:0]             enemy_alive,
    input  logic                               pause,
    output logic [LEVEL_W-1:0]                 level,
    output logic                               level_up_out,
    output logic                               transition_active,
    output logic                               game_won,
    output logic [$clog2(NUM_ENEMIES+1)-1:0]   enemies_left
);

    localparam int POP_W = $clog2(NUM_ENEMIES + 1);
    localparam int CNT_W = $clog2(max_int(DELAY_CYCLES, RESPAWN_CYCLES) + 1);

    localparam logic [CNT_W-1:0]   CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0]   DELAY_LAST = CNT_W'(DELAY_CYCLES - 1);
    localparam logic [CNT_W-1:0]   RESP_LAST  = CNT_W'(RESPAWN_CYCLES - 1);
    localparam logic [LEVEL_W-1:0] LEVEL_ONE  = LEVEL_W'(32'd1);
    localparam logic [LEVEL_W-1:0] LEVEL_MAX  = LEVEL_W'(MAX_LEVEL);

    // Elaboration-time parameter sanity checks.
    if (NUM_ENEMIES < 1) begin : g_chk_num
        $error("level_ctrl: NUM_ENEMIES must be >= 1");
    end
    if ((MAX_LEVEL < 1) || (MAX_LEVEL >= (1 << LEVEL_W))) begin : g_chk_max
        $error("level_ctrl: MAX_LEVEL must satisfy 1 <= MAX_LEVEL < 2**LEVEL_W");
    end
    if (DELAY_CYCLES < 1) begin : g_chk_delay
        $error("level_ctrl: DELAY_CYCLES must be >= 1");
    end
    if (RESPAWN_CYCLES < 1) begin : g_chk_resp
        $error("level_ctrl: RESPAWN_CYCLES must be >= 1");
    end

    level_state_e        state_r;
    level_state_e        state_nxt_s;
    logic [CNT_W-1:0]    cnt_r;
    logic [CNT_W-1:0]    cnt_nxt_s;
    logic                armed_r;
    logic                armed_nxt_s;
    logic [LEVEL_W-1:0]  level_r;
    logic [LEVEL_W-1:0]  level_nxt_s;
    logic [POP_W-1:0]    pop_s;
    logic                any_alive_s;
    logic                clear_s;

    logic                up_r;
    logic                ta_r;
    logic                won_r;
    logic [POP_W-1:0]    left_r;
    logic                up_nxt_s;
    logic                ta_nxt_s;
    logic                won_nxt_s;

    enemy_popcount #(
        .N (NUM_ENEMIES),
        .W (POP_W)
    ) u_popcount (
        .alive (enemy_alive),
        .count (pop_s)
    );

    assign any_alive_s = |enemy_alive;
    // A wave only counts as cleared after enemies were seen since the last
    // respawn, so late-appearing respawned enemies cannot double-trigger.
    assign clear_s     = armed_r && (enemy_alive == {NUM_ENEMIES{1'b0}});

    // State register plus the counter, armed flag and level datapath.
    always_ff @(posedge pclk) begin
        if (rst) begin
            state_r <= ST_PLAY;
            cnt_r   <= CNT_ZERO;
            armed_r <= 1'b0;
            level_r <= LEVEL_ONE;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            armed_r <= armed_nxt_s;
            level_r <= level_nxt_s;
        end
    end

    // Next-state logic; the single counter serves both the banner and strobe dwell.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        armed_nxt_s = armed_r;
        level_nxt_s = level_r;
        case (state_r)
            ST_PLAY: begin
                if (clear_s) begin
                    armed_nxt_s = 1'b0;
                    cnt_nxt_s   = CNT_ZERO;
                    if (level_r < LEVEL_MAX) begin
                        level_nxt_s = level_r + LEVEL_ONE;
                        state_nxt_s = ST_CLEAR_WAIT;
                    end else if (WRAP_EN) begin
                        level_nxt_s = LEVEL_ONE;
                        state_nxt_s = ST_CLEAR_WAIT;
                    end else begin
                        state_nxt_s = ST_WON;
                    end
                end else if (any_alive_s) begin
                    armed_nxt_s = 1'b1;
                end else begin
                    armed_nxt_s = armed_r;
                end
            end
            ST_CLEAR_WAIT: begin
                if (pause) begin
                    cnt_nxt_s = cnt_r;
                end else if (cnt_r == DELAY_LAST) begin
                    cnt_nxt_s   = CNT_ZERO;
                    state_nxt_s = ST_RESPAWN;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            ST_RESPAWN: begin
                if (cnt_r == RESP_LAST) begin
                    cnt_nxt_s   = CNT_ZERO;
                    armed_nxt_s = 1'b0;
                    state_nxt_s = ST_PLAY;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            ST_WON: begin
                state_nxt_s = ST_WON;
            end
            default: begin
                state_nxt_s = ST_PLAY;
                cnt_nxt_s   = CNT_ZERO;
                armed_nxt_s = 1'b0;
                level_nxt_s = LEVEL_ONE;
            end
        endcase
    end

    // Output decode from the next state so outputs move with the state register.
    always_comb begin
        up_nxt_s  = (state_nxt_s == ST_RESPAWN);
        ta_nxt_s  = (state_nxt_s == ST_CLEAR_WAIT);
        won_nxt_s = (state_nxt_s == ST_WON);
    end

    // Output registers, including the one-cycle-latency enemy count.
    always_ff @(posedge pclk) begin
        if (rst) begin
            up_r   <= 1'b0;
            ta_r   <= 1'b0;
            won_r  <= 1'b0;
            left_r <= {POP_W{1'b0}};
        end else begin
            up_r   <= up_nxt_s;
            ta_r   <= ta_nxt_s;
            won_r  <= won_nxt_s;
            left_r <= pop_s;
        end
    end

    assign level             = level_r;
    assign level_up_out      = up_r;
    assign transition_active = ta_r;
    assign game_won          = won_r;
    assign enemies_left      = left_r;

endmodule

// File: tb/tb_level_ctrl.sv
// Directed bench for level_ctrl. Two instances share all stimulus: one
// stops in WON at the level cap, the other wraps back to level 1.
module tb_level_ctrl;

    localparam int NUM_ENEMIES    = 5;
    localparam int LEVEL_W        = 4;
    localparam int MAX_LEVEL      = 3;
    localparam int DELAY_CYCLES   = 8;
    localparam int RESPAWN_CYCLES = 3;

    logic       pclk = 1'b0;
    logic       rst;
    logic       pause;
    logic [4:0] enemy_alive;

    logic [3:0] level_a, level_b;
    logic       up_a, up_b, ta_a, ta_b, won_a, won_b;
    logic [2:0] left_a, left_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 pclk = ~pclk;

    level_ctrl #(
        .NUM_ENEMIES(NUM_ENEMIES), .LEVEL_W(LEVEL_W), .MAX_LEVEL(MAX_LEVEL),
        .DELAY_CYCLES(DELAY_CYCLES), .RESPAWN_CYCLES(RESPAWN_CYCLES), .WRAP_EN(1'b0)
    ) u_won (
        .pclk(pclk), .rst(rst), .enemy_alive(enemy_alive), .pause(pause),
        .level(level_a), .level_up_out(up_a), .transition_active(ta_a),
        .game_won(won_a), .enemies_left(left_a)
    );

    level_ctrl #(
        .NUM_ENEMIES(NUM_ENEMIES), .LEVEL_W(LEVEL_W), .MAX_LEVEL(MAX_LEVEL),
        .DELAY_CYCLES(DELAY_CYCLES), .RESPAWN_CYCLES(RESPAWN_CYCLES), .WRAP_EN(1'b1)
    ) u_wrap (
        .pclk(pclk), .rst(rst), .enemy_alive(enemy_alive), .pause(pause),
        .level(level_b), .level_up_out(up_b), .transition_active(ta_b),
        .game_won(won_b), .enemies_left(left_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic tick_both(input string tag, input logic exp_ta, input logic exp_up);
        tick();
        chk({tag, "_ta_a"}, {31'd0, ta_a}, {31'd0, exp_ta});
        chk({tag, "_ta_b"}, {31'd0, ta_b}, {31'd0, exp_ta});
        chk({tag, "_up_a"}, {31'd0, up_a}, {31'd0, exp_up});
        chk({tag, "_up_b"}, {31'd0, up_b}, {31'd0, exp_up});
    endtask

    initial begin
        rst         = 1'b1;
        pause       = 1'b0;
        enemy_alive = 5'b00000;
        tick();
        tick();
        chk("rst_level_a", {28'd0, level_a}, 32'd1);
        chk("rst_level_b", {28'd0, level_b}, 32'd1);
        chk("rst_up",      {31'd0, up_a},    32'd0);
        chk("rst_ta",      {31'd0, ta_a},    32'd0);
        chk("rst_won",     {31'd0, won_a},   32'd0);
        chk("rst_left",    {29'd0, left_a},  32'd0);

        // Test 1: kill one enemy per cycle; the clear edge starts the banner.
        rst         = 1'b0;
        enemy_alive = 5'b11111;
        for (int i = 5; i >= 0; i--) begin
            tick();
            chk("t1_left_a", {29'd0, left_a}, i);
            chk("t1_left_b", {29'd0, left_b}, i);
            enemy_alive = enemy_alive >> 1;
        end
        chk("t1_level_a", {28'd0, level_a}, 32'd2);
        chk("t1_level_b", {28'd0, level_b}, 32'd2);
        chk("t1_ta0",     {31'd0, ta_a},    32'd1);
        chk("t1_up0",     {31'd0, up_a},    32'd0);
        for (int i = 0; i < 7; i++) tick_both("t1_wait", 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) tick_both("t1_strobe", 1'b0, 1'b1);
        tick_both("t1_end", 1'b0, 1'b0);

        // Test 3: 5 paused cycles stretch the banner to 13; pause in RESPAWN has no effect.
        enemy_alive = 5'b11111;
        tick();
        enemy_alive = 5'b00000;
        tick();
        chk("t3_level_a", {28'd0, level_a}, 32'd3);
        chk("t3_ta0",     {31'd0, ta_a},    32'd1);
        pause = 1'b1;
        for (int i = 0; i < 5; i++) tick_both("t3_paused", 1'b1, 1'b0);
        pause = 1'b0;
        for (int i = 0; i < 7; i++) tick_both("t3_wait", 1'b1, 1'b0);
        tick_both("t3_strobe", 1'b0, 1'b1);
        pause = 1'b1;
        for (int i = 0; i < 2; i++) tick_both("t3_strobe_p", 1'b0, 1'b1);
        tick_both("t3_end", 1'b0, 1'b0);
        pause = 1'b0;

        // Test 4: zeros after respawn do not clear (disarmed); a later 1->0 does.
        enemy_alive = 5'b00000;
        for (int i = 0; i < 4; i++) tick_both("t4_idle", 1'b0, 1'b0);
        chk("t4_level_a", {28'd0, level_a}, 32'd3);
        chk("t4_level_b", {28'd0, level_b}, 32'd3);
        enemy_alive = 5'b00001;
        tick();
        chk("t4_left", {29'd0, left_a}, 32'd1);
        enemy_alive = 5'b00000;
        tick();

        // Test 5: clear at the cap -> WON (no wrap) versus level 1 (wrap).
        chk("t5_won_a",   {31'd0, won_a},   32'd1);
        chk("t5_level_a", {28'd0, level_a}, 32'd3);
        chk("t5_ta_a",    {31'd0, ta_a},    32'd0);
        chk("t5_up_a",    {31'd0, up_a},    32'd0);
        chk("t5_won_b",   {31'd0, won_b},   32'd0);
        chk("t5_level_b", {28'd0, level_b}, 32'd1);
        chk("t5_ta_b",    {31'd0, ta_b},    32'd1);
        enemy_alive = 5'b11111;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("t5_wait_ta_b", {31'd0, ta_b},  32'd1);
            chk("t5_wait_won",  {31'd0, won_a}, 32'd1);
            chk("t5_wait_up_a", {31'd0, up_a},  32'd0);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5_strobe_b",  {31'd0, up_b},  32'd1);
            chk("t5_strobe_ta", {31'd0, ta_b},  32'd0);
            chk("t5_won_up_a",  {31'd0, up_a},  32'd0);
            chk("t5_won_hold",  {31'd0, won_a}, 32'd1);
        end
        tick();
        chk("t5_end_up_b",   {31'd0, up_b},    32'd0);
        chk("t5_end_won",    {31'd0, won_a},   32'd1);
        chk("t5_end_level",  {28'd0, level_a}, 32'd3);
        chk("t5_end_levelb", {28'd0, level_b}, 32'd1);

        // Test 2: reset leaves WON; enemies never seen -> never armed, no level-up.
        rst         = 1'b1;
        enemy_alive = 5'b00000;
        tick();
        chk("t2_won_cleared", {31'd0, won_a},   32'd0);
        chk("t2_level_rst",   {28'd0, level_a}, 32'd1);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("t2_level_a", {28'd0, level_a}, 32'd1);
            chk("t2_level_b", {28'd0, level_b}, 32'd1);
            chk("t2_ta_a",    {31'd0, ta_a},    32'd0);
        end

        // Test 6a: reset with the banner counter at 4.
        enemy_alive = 5'b00001;
        tick();
        enemy_alive = 5'b00000;
        tick();
        chk("t6_ta0", {31'd0, ta_a}, 32'd1);
        for (int i = 0; i < 4; i++) tick_both("t6_wait", 1'b1, 1'b0);
        rst         = 1'b1;
        enemy_alive = 5'b11111;
        tick();
        chk("t6a_level", {28'd0, level_a}, 32'd1);
        chk("t6a_ta",    {31'd0, ta_a},    32'd0);
        chk("t6a_up",    {31'd0, up_a},    32'd0);
        chk("t6a_left",  {29'd0, left_a},  32'd0);
        rst         = 1'b0;
        enemy_alive = 5'b00000;
        for (int i = 0; i < 12; i++) tick_both("t6a_after", 1'b0, 1'b0);

        // Test 6b: reset in the middle of the respawn strobe.
        enemy_alive = 5'b00001;
        tick();
        enemy_alive = 5'b00000;
        tick();
        chk("t6b_level2", {28'd0, level_a}, 32'd2);
        for (int i = 0; i < 7; i++) tick_both("t6b_wait", 1'b1, 1'b0);
        tick_both("t6b_strobe", 1'b0, 1'b1);
        tick_both("t6b_strobe", 1'b0, 1'b1);
        rst = 1'b1;
        tick();
        chk("t6b_up",    {31'd0, up_a},    32'd0);
        chk("t6b_ta",    {31'd0, ta_a},    32'd0);
        chk("t6b_level", {28'd0, level_a}, 32'd1);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) tick_both("t6b_after", 1'b0, 1'b0);
        chk("t6b_level_end", {28'd0, level_b}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
